// File: rtl/ddr_preload_engine_if.sv
// DDR control bus between the preload engine (master) and avalon_mm_ddr (slave).
// Carries the wr_rq/action_done write handshake and the rd_rq/rd_valid read-back channel.
interface ddr_preload_engine_if #(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned ADDR_W = 25
);
  logic                  wr_rq;
  logic [ADDR_W-1:0]     wr_adr;
  logic [DATA_W-1:0]     wr_data;
  logic [DATA_W/8-1:0]   byte_enable;
  logic                  action_done;
  logic                  rd_rq;
  logic [ADDR_W-1:0]     rd_adr;
  logic                  rd_valid;
  logic [DATA_W-1:0]     rd_data;

  modport master (
    output wr_rq, wr_adr, wr_data, byte_enable, rd_rq, rd_adr,
    input  action_done, rd_valid, rd_data
  );

  modport slave (
    input  wr_rq, wr_adr, wr_data, byte_enable, rd_rq, rd_adr,
    output action_done, rd_valid, rd_data
  );
endinterface

// File: rtl/ddr_preload_engine.sv
// Post-calibration DDR preload: packs source-table words LSB-first into beats and writes them.
// Define DDR_PRELOAD_VERIFY_EN to add a read-back verify pass after the last write.
module ddr_preload_engine #(
  parameter int unsigned DATA_W    = 256,
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned ADDR_W    = 25,
  parameter int unsigned NUM_WORDS = 28,
  parameter int unsigned SRC_AW    = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   ddr_ready,
  input  logic [ADDR_W-1:0]      base_addr,
  output logic [SRC_AW-1:0]      src_addr,
  input  logic [WORD_W-1:0]      src_data,
  ddr_preload_engine_if.master   ddr,
  output logic                   busy,
  output logic                   setup_done,
  output logic                   verify_fail,
  output logic [15:0]            beats_done
);

  localparam int unsigned R          = DATA_W / WORD_W;
  localparam int unsigned WB         = WORD_W / 8;
  localparam int unsigned NB         = (NUM_WORDS + R - 1) / R;
  localparam int unsigned LAST_LANES = NUM_WORDS - (NB - 1) * R;
  localparam int unsigned CW         = $clog2(R + 1) + 1;
  localparam int unsigned LW         = (R > 1) ? $clog2(R) : 1;

  typedef enum logic [2:0] {
    StIdle, StWaitRdy, StFetch, StWrite, StVerifyRd, StVerifyChk, StDone
  } state_e;

  state_e                state_q;
  logic [ADDR_W-1:0]     base_q;
  logic [SRC_AW-1:0]     src_addr_q;
  logic [CW-1:0]         cnt_q;
  logic                  pend_q;
  logic [LW-1:0]         pend_lane_q;
  logic [15:0]           beat_q;
  logic [DATA_W-1:0]     data_q;
  logic                  wr_rq_q;
  logic [ADDR_W-1:0]     wr_adr_q;
  logic [DATA_W/8-1:0]   be_q;
  logic                  busy_q;
  logic                  setup_done_q;
  logic [15:0]           beats_done_q;

  logic [CW-1:0]         lanes;
  logic [DATA_W/8-1:0]   be_beat;

  assign lanes = (beat_q == 16'(NB - 1)) ? CW'(LAST_LANES) : CW'(R);

  always_comb begin
    be_beat = '0;
    for (int unsigned l = 0; l < R; l++) begin
      if (CW'(l) < lanes) be_beat[l*WB +: WB] = '1;
    end
  end

`ifdef DDR_PRELOAD_VERIFY_EN
  logic                  rd_rq_q;
  logic [ADDR_W-1:0]     rd_adr_q;
  logic [DATA_W-1:0]     rd_buf_q;
  logic                  vfail_q;
  logic [DATA_W-1:0]     bit_mask;

  always_comb begin
    bit_mask = '0;
    for (int unsigned i = 0; i < DATA_W / 8; i++) bit_mask[i*8 +: 8] = {8{be_beat[i]}};
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      base_q       <= '0;
      src_addr_q   <= '0;
      cnt_q        <= '0;
      pend_q       <= 1'b0;
      pend_lane_q  <= '0;
      beat_q       <= '0;
      data_q       <= '0;
      wr_rq_q      <= 1'b0;
      wr_adr_q     <= '0;
      be_q         <= '0;
      busy_q       <= 1'b0;
      setup_done_q <= 1'b0;
      beats_done_q <= '0;
`ifdef DDR_PRELOAD_VERIFY_EN
      rd_rq_q      <= 1'b0;
      rd_adr_q     <= '0;
      rd_buf_q     <= '0;
      vfail_q      <= 1'b0;
`endif
    end else begin
      // Source data lags its address by one cycle; drop it into the lane recorded then.
      if (pend_q) data_q[pend_lane_q*WORD_W +: WORD_W] <= src_data;
      pend_q <= 1'b0;

      if (state_q != StIdle && state_q != StDone && !ddr_ready) begin
        state_q      <= StWaitRdy;
        wr_rq_q      <= 1'b0;
        beats_done_q <= '0;
`ifdef DDR_PRELOAD_VERIFY_EN
        rd_rq_q      <= 1'b0;
`endif
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start) begin
              base_q       <= base_addr;
              setup_done_q <= 1'b0;
              beats_done_q <= '0;
              busy_q       <= 1'b1;
              state_q      <= StWaitRdy;
`ifdef DDR_PRELOAD_VERIFY_EN
              vfail_q      <= 1'b0;
`endif
            end
          end
          StWaitRdy: begin
            state_q    <= StFetch;
            src_addr_q <= '0;
            cnt_q      <= '0;
            beat_q     <= '0;
            data_q     <= '0;
          end
          StFetch: begin
            if (cnt_q == lanes) begin
              state_q  <= StWrite;
              wr_rq_q  <= 1'b1;
              wr_adr_q <= base_q + ADDR_W'(beat_q);
              be_q     <= be_beat;
            end else begin
              pend_q      <= 1'b1;
              pend_lane_q <= LW'(cnt_q);
              src_addr_q  <= src_addr_q + SRC_AW'(1);
              cnt_q       <= cnt_q + CW'(1);
            end
          end
          StWrite: begin
            if (ddr.action_done) begin
              wr_rq_q      <= 1'b0;
              beats_done_q <= beats_done_q + 16'd1;
              cnt_q        <= '0;
              data_q       <= '0;
              if (beat_q == 16'(NB - 1)) begin
`ifdef DDR_PRELOAD_VERIFY_EN
                state_q    <= StVerifyRd;
                beat_q     <= '0;
                src_addr_q <= '0;
`else
                state_q      <= StDone;
                busy_q       <= 1'b0;
                setup_done_q <= 1'b1;
`endif
              end else begin
                state_q <= StFetch;
                beat_q  <= beat_q + 16'd1;
              end
            end
          end
`ifdef DDR_PRELOAD_VERIFY_EN
          StVerifyRd: begin
            if (rd_rq_q) begin
              if (ddr.rd_valid) begin
                rd_rq_q  <= 1'b0;
                rd_buf_q <= ddr.rd_data;
                state_q  <= StVerifyChk;
              end
            end else if (cnt_q == lanes) begin
              rd_rq_q  <= 1'b1;
              rd_adr_q <= base_q + ADDR_W'(beat_q);
            end else begin
              pend_q      <= 1'b1;
              pend_lane_q <= LW'(cnt_q);
              src_addr_q  <= src_addr_q + SRC_AW'(1);
              cnt_q       <= cnt_q + CW'(1);
            end
          end
          StVerifyChk: begin
            if (((rd_buf_q ^ data_q) & bit_mask) != '0) vfail_q <= 1'b1;
            cnt_q  <= '0;
            data_q <= '0;
            if (beat_q == 16'(NB - 1)) begin
              state_q      <= StDone;
              busy_q       <= 1'b0;
              setup_done_q <= 1'b1;
            end else begin
              state_q <= StVerifyRd;
              beat_q  <= beat_q + 16'd1;
            end
          end
`endif
          StDone:  state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign src_addr        = src_addr_q;
  assign ddr.wr_rq       = wr_rq_q;
  assign ddr.wr_adr      = wr_adr_q;
  assign ddr.wr_data     = data_q;
  assign ddr.byte_enable = be_q;
  assign busy            = busy_q;
  assign setup_done      = setup_done_q;
  assign beats_done      = beats_done_q;

`ifdef DDR_PRELOAD_VERIFY_EN
  assign ddr.rd_rq   = rd_rq_q;
  assign ddr.rd_adr  = rd_adr_q;
  assign verify_fail = vfail_q;
`else
  logic unused_rd;
  assign unused_rd   = ^{ddr.rd_valid, ddr.rd_data};
  assign ddr.rd_rq   = 1'b0;
  assign ddr.rd_adr  = '0;
  assign verify_fail = 1'b0;
`endif

endmodule

// File: tb/tb_ddr_preload_engine.sv
// Directed bench for ddr_preload_engine: default 256-bit instance plus a 64-bit, 5-word instance.
// Verify-pass expectations switch on DDR_PRELOAD_VERIFY_EN.
module tb_ddr_preload_engine;

  logic clk = 1'b0;
  logic rst_n, start, start64, ddr_ready, spur_ad, flip_en;
  logic [24:0] base_addr, base64;
  logic [9:0]  src_addr, src_addr64;
  logic [31:0] src_data, src_data64;
  logic busy, setup_done, verify_fail, busy64, setup_done64, verify_fail64;
  logic [15:0] beats_done, beats_done64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ddr_preload_engine_if #(.DATA_W(256), .ADDR_W(25)) bus ();
  ddr_preload_engine_if #(.DATA_W(64),  .ADDR_W(25)) bus64 ();

  ddr_preload_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ddr_ready(ddr_ready), .base_addr(base_addr),
    .src_addr(src_addr), .src_data(src_data), .ddr(bus), .busy(busy),
    .setup_done(setup_done), .verify_fail(verify_fail), .beats_done(beats_done)
  );

  ddr_preload_engine #(.DATA_W(64), .WORD_W(32), .ADDR_W(25), .NUM_WORDS(5), .SRC_AW(10)) dut64 (
    .clk(clk), .rst_n(rst_n), .start(start64), .ddr_ready(ddr_ready), .base_addr(base64),
    .src_addr(src_addr64), .src_data(src_data64), .ddr(bus64), .busy(busy64),
    .setup_done(setup_done64), .verify_fail(verify_fail64), .beats_done(beats_done64)
  );

  // Source tables: word k holds value k, one-cycle read latency.
  always @(posedge clk) begin
    src_data   <= 32'(src_addr);
    src_data64 <= 32'(src_addr64);
  end

  // Write responders: action_done three cycles into each request; accepted beats are logged.
  int wcnt, wcnt64, wr_cnt, wr_cnt64, rcnt, rcnt64, rd_cnt, rd_cnt64;
  logic resp_ad, resp_ad64;
  logic [24:0]  log_adr   [16];
  logic [255:0] log_dat   [16];
  logic [31:0]  log_be    [16];
  logic [24:0]  log64_adr [16];
  logic [63:0]  log64_dat [16];
  logic [7:0]   log64_be  [16];
  logic [255:0] mem   [4];
  logic [63:0]  mem64 [4];

  assign bus.action_done   = resp_ad | spur_ad;
  assign bus64.action_done = resp_ad64;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= 0; resp_ad <= 1'b0; wr_cnt <= 0;
    end else begin
      resp_ad <= 1'b0;
      if (bus.wr_rq && !resp_ad) begin
        if (wcnt == 2) begin resp_ad <= 1'b1; wcnt <= 0; end
        else wcnt <= wcnt + 1;
      end else wcnt <= 0;
      if (bus.wr_rq && bus.action_done && wr_cnt < 16) begin
        log_adr[wr_cnt] <= bus.wr_adr;
        log_dat[wr_cnt] <= bus.wr_data;
        log_be[wr_cnt]  <= bus.byte_enable;
        mem[bus.wr_adr[1:0]] <= bus.wr_data;
        wr_cnt <= wr_cnt + 1;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt64 <= 0; resp_ad64 <= 1'b0; wr_cnt64 <= 0;
    end else begin
      resp_ad64 <= 1'b0;
      if (bus64.wr_rq && !resp_ad64) begin
        if (wcnt64 == 2) begin resp_ad64 <= 1'b1; wcnt64 <= 0; end
        else wcnt64 <= wcnt64 + 1;
      end else wcnt64 <= 0;
      if (bus64.wr_rq && bus64.action_done && wr_cnt64 < 16) begin
        log64_adr[wr_cnt64] <= bus64.wr_adr;
        log64_dat[wr_cnt64] <= bus64.wr_data;
        log64_be[wr_cnt64]  <= bus64.byte_enable;
        mem64[bus64.wr_adr[1:0]] <= bus64.wr_data;
        wr_cnt64 <= wr_cnt64 + 1;
      end
    end
  end

  // Read responders return stored beats; flip_en corrupts bit 0 of the beat at 0x..1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt <= 0; rd_cnt <= 0; bus.rd_valid <= 1'b0; bus.rd_data <= '0;
    end else begin
      bus.rd_valid <= 1'b0;
      if (bus.rd_rq && !bus.rd_valid) begin
        if (rcnt == 1) begin
          bus.rd_valid <= 1'b1;
          bus.rd_data  <= mem[bus.rd_adr[1:0]] ^
                          256'((flip_en && bus.rd_adr[1:0] == 2'd1) ? 1 : 0);
          rd_cnt <= rd_cnt + 1;
          rcnt <= 0;
        end else rcnt <= rcnt + 1;
      end else rcnt <= 0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt64 <= 0; rd_cnt64 <= 0; bus64.rd_valid <= 1'b0; bus64.rd_data <= '0;
    end else begin
      bus64.rd_valid <= 1'b0;
      if (bus64.rd_rq && !bus64.rd_valid) begin
        if (rcnt64 == 1) begin
          bus64.rd_valid <= 1'b1;
          bus64.rd_data  <= mem64[bus64.rd_adr[1:0]];
          rd_cnt64 <= rd_cnt64 + 1;
          rcnt64 <= 0;
        end else rcnt64 <= rcnt64 + 1;
      end else rcnt64 <= 0;
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Beat b of the default table: lane l carries word 8*b+l while it is below 28.
  function automatic logic [255:0] exp_beat(input int b);
    logic [255:0] v = '0;
    for (int l = 0; l < 8; l++) if (8 * b + l < 28) v[32*l +: 32] = 32'(8 * b + l);
    return v;
  endfunction

  int n, base_idx, rd_base;
  bit seen;

  initial begin
    rst_n = 1'b0; start = 1'b0; start64 = 1'b0; ddr_ready = 1'b0; spur_ad = 1'b0;
    flip_en = 1'b0; base_addr = '0; base64 = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",         256'(busy),         0);
    chk("rst_setup_done",   256'(setup_done),   0);
    chk("rst_verify_fail",  256'(verify_fail),  0);
    chk("rst_beats_done",   256'(beats_done),   0);
    chk("rst_wr_rq",        256'(bus.wr_rq),    0);
    chk("rst_rd_rq",        256'(bus.rd_rq),    0);
    chk("rst_src_addr",     256'(src_addr),     0);
    chk("rst_setup_done64", 256'(setup_done64), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Start while DDR is not ready: engine waits with busy set.
    base_addr = 25'h100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    repeat (500) begin
      @(negedge clk);
      if (bus.wr_rq) seen = 1'b1;
    end
    chk("notready_wr_rq", 256'(seen), 0);
    chk("notready_busy",  256'(busy), 1);

    ddr_ready = 1'b1;
    n = 0;
    while (!bus.wr_rq && n < 50) begin @(negedge clk); n++; end
    chk("first_write_within_R_plus_2", 256'(n <= 10), 1);

    // Spurious start (new base) and action_done with wr_rq low must change nothing.
    n = 0;
    while (beats_done != 16'd1 && n < 100) begin @(negedge clk); n++; end
    chk("beat0_completed", 256'(beats_done), 1);
    start = 1'b1; base_addr = 25'h55; spur_ad = 1'b1;
    @(negedge clk);
    start = 1'b0; spur_ad = 1'b0; base_addr = 25'h100;
    chk("spurious_beats_done", 256'(beats_done), 1);
    chk("spurious_wr_rq",      256'(bus.wr_rq),  0);

    n = 0;
    while (!setup_done && n < 2000) begin @(negedge clk); n++; end
    chk("run1_setup_done",  256'(setup_done),  1);
    chk("run1_busy",        256'(busy),        0);
    chk("run1_beats_done",  256'(beats_done),  4);
    chk("run1_writes",      256'(wr_cnt),      4);
    chk("run1_verify_fail", 256'(verify_fail), 0);
    for (int b = 0; b < 4; b++) begin
      chk("run1_wr_adr",  256'(log_adr[b]), 256'(25'h100 + 25'(b)));
      chk("run1_wr_data", log_dat[b],       exp_beat(b));
      chk("run1_byte_en", 256'(log_be[b]),  256'((b < 3) ? 32'hFFFF_FFFF : 32'h0000_FFFF));
    end

    // Drop ddr_ready while beat 2 is being requested; rerun must restart at the base.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("run2_setup_cleared", 256'(setup_done), 0);
    n = 0;
    while (!(beats_done == 16'd2 && bus.wr_rq) && n < 200) begin @(negedge clk); n++; end
    chk("run2_beat2_requested", 256'(beats_done == 16'd2 && bus.wr_rq), 1);
    base_idx = wr_cnt;
    ddr_ready = 1'b0;
    @(negedge clk);
    chk("abort_wr_rq",      256'(bus.wr_rq),  0);
    chk("abort_beats_done", 256'(beats_done), 0);
    chk("abort_busy",       256'(busy),       1);
    repeat (5) @(negedge clk);
    ddr_ready = 1'b1;
    n = 0;
    while (!setup_done && n < 2000) begin @(negedge clk); n++; end
    chk("run2_setup_done", 256'(setup_done),      1);
    chk("run2_beats_done", 256'(beats_done),      4);
    chk("run2_writes",     256'(wr_cnt - base_idx), 4);
    chk("run2_first_adr",  256'(log_adr[base_idx]),     256'(25'h100));
    chk("run2_last_adr",   256'(log_adr[base_idx + 3]), 256'(25'h103));
    chk("run2_last_data",  log_dat[base_idx + 3],       exp_beat(3));

    // 64-bit beats, 5 words, base at the top of the address space.
    base64 = 25'h1FF_FFFF; start64 = 1'b1;
    @(negedge clk);
    start64 = 1'b0;
    n = 0;
    while (!setup_done64 && n < 1000) begin @(negedge clk); n++; end
    chk("w64_setup_done", 256'(setup_done64), 1);
    chk("w64_beats_done", 256'(beats_done64), 3);
    chk("w64_writes",     256'(wr_cnt64),     3);
    chk("w64_adr0",  256'(log64_adr[0]), 256'(25'h1FF_FFFF));
    chk("w64_adr1",  256'(log64_adr[1]), 0);
    chk("w64_adr2",  256'(log64_adr[2]), 1);
    chk("w64_data0", 256'(log64_dat[0]), 256'(64'h0000_0001_0000_0000));
    chk("w64_data1", 256'(log64_dat[1]), 256'(64'h0000_0003_0000_0002));
    chk("w64_data2", 256'(log64_dat[2]), 256'(64'h0000_0000_0000_0004));
    chk("w64_be0",   256'(log64_be[0]),  256'(8'hFF));
    chk("w64_be2",   256'(log64_be[2]),  256'(8'h0F));

    // Corrupt read-back of beat 1.
    flip_en = 1'b1;
    rd_base = rd_cnt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!setup_done && n < 3000) begin @(negedge clk); n++; end
    chk("vfy_setup_done", 256'(setup_done), 1);
`ifdef DDR_PRELOAD_VERIFY_EN
    chk("vfy_verify_fail", 256'(verify_fail),      1);
    chk("vfy_reads",       256'(rd_cnt - rd_base), 4);
    chk("vfy64_clean",     256'(verify_fail64),    0);
`else
    chk("novfy_verify_fail", 256'(verify_fail), 0);
    chk("novfy_reads",       256'(rd_cnt),      0);
    chk("novfy_rd_adr",      256'(bus.rd_adr),  0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr_preload_engine.md
Name: ddr_preload_engine

Overview:
- Parametrised DDR preload engine that runs after calibration.
- Fetches NUM_WORDS words of WORD_W bits from a synchronous source table and packs them LSB-first into DATA_W-bit beats.
- Writes the beats to consecutive DDR addresses through the avalon_mm_ddr control interface (wr_rq/action_done).
- Sits between the packet/test-data ROM and avalon_mm_ddr; generalises the fixed 256-bit, 28-word setup path to any width, depth and base address, with restart and optional read-back verification.

Parameters:
- DATA_W, 256, DDR beat width; must be an integer multiple of WORD_W.
- WORD_W, 32, source word width; must be a multiple of 8.
- ADDR_W, 25, DDR beat address width.
- NUM_WORDS, 28, words to preload; range 1 to 2**SRC_AW.
- SRC_AW, 10, source table address width.

Ports:
- clk  in  1  clock; all logic in this one domain.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to run a preload.
- ddr_ready  in  1  DDR calibration success, already synchronised to clk.
- base_addr  in  ADDR_W  first beat address; sampled on an accepted start.
- src_addr  out  SRC_AW  source table read address.
- src_data  in  WORD_W  source table data; valid 1 cycle after src_addr.
- wr_rq  out  1  write request.
- wr_adr  out  ADDR_W  write beat address.
- wr_data  out  DATA_W  write beat data.
- byte_enable  out  DATA_W/8  write byte enables.
- action_done  in  1  one-cycle completion of the current request.
- rd_rq  out  1  read request (verify only).
- rd_adr  out  ADDR_W  read beat address.
- rd_valid  in  1  read data valid.
- rd_data  in  DATA_W  read data.
- busy  out  1  run in progress.
- setup_done  out  1  sticky run-complete flag.
- verify_fail  out  1  sticky mismatch flag.
- beats_done  out  16  count of beats completed in the current run.

Behaviour:
- Derived values:
  - R = DATA_W/WORD_W.
  - NB = ceil(NUM_WORDS/R).
  - Word k goes to beat k/R, lane k mod R, at bits [WORD_W*(k mod R) +: WORD_W].
- Reset values: all outputs 0, state IDLE.
- States: IDLE, WAIT_RDY, FETCH, WRITE, VERIFY_RD, VERIFY_CHK, DONE.
- IDLE:
  - start=1 latches base_addr.
  - Clears setup_done, verify_fail and beats_done.
  - Next state WAIT_RDY.
- WAIT_RDY: ddr_ready=1 -> FETCH with word index 0.
- FETCH:
  - Issues src_addr = word index, one word per cycle.
  - Each word is captured into its lane 1 cycle later.
  - A beat's data is complete R+1 cycles after its first address; for the last beat, lanes+1 cycles.
  - Lanes beyond NUM_WORDS in the last beat are 0, and their byte_enable bits are 0.
  - All other beats use byte_enable all-ones.
- WRITE:
  - wr_rq=1 with wr_adr = base + beat index; wr_adr, wr_data and byte_enable held stable.
  - action_done=1 completes the beat: wr_rq drops the same edge and beats_done increments.
  - action_done while wr_rq=0 is ignored.
  - After the beat: next beat -> FETCH; after beat NB-1 -> VERIFY_RD if enabled, else DONE.
- DONE:
  - setup_done=1 and busy=0, then return to IDLE.
  - setup_done holds until the next accepted start.
- busy = 1 in every state except IDLE and DONE.
- start while busy is ignored.
- ddr_ready falls while busy:
  - Abort on the next edge: wr_rq/rd_rq=0 and any pending handshake is discarded.
  - beats_done cleared, return to WAIT_RDY, rerun from word 0 with the same latched base.
- Address arithmetic wraps modulo 2**ADDR_W; no error is raised.
- NUM_WORDS < R: single partial beat.

Optional Feature:
- Macro: DDR_PRELOAD_VERIFY_EN.
- With the macro, after the last write:
  - For each beat b, VERIFY_RD asserts rd_rq and rd_adr = base + b, held until rd_valid.
  - The beat is re-packed from the source table.
  - Only enabled bytes are compared; a mismatch sets verify_fail.
  - Verify continues through all beats, then DONE.
- Without the macro: rd_rq and rd_adr stay 0, verify_fail stays 0, and rd_valid/rd_data are unused.

Test Plan:
- Defaults, base_addr=0x100, table word k = k, action_done 3 cycles after each wr_rq:
  - Expect 4 writes to 0x100..0x103, beats_done=4, setup_done=1.
  - Beat 3 = words 24..27 in lanes 0..3, byte_enable 0x0000FFFF; beats 0..2 use 0xFFFFFFFF.
- Hold ddr_ready=0 for 500 cycles after start -> wr_rq stays 0 and busy=1; raise ddr_ready -> first write within R+2 cycles.
- Drop ddr_ready while beat 2 has wr_rq=1 -> wr_rq falls next edge, beats_done=0; on recovery writes restart at 0x100 and 4 beats total complete.
- Pulse start during a run, and pulse action_done with wr_rq=0 -> no extra writes and no change to beats_done.
- Set DATA_W=64, NUM_WORDS=5, base_addr=2**25-1 -> 3 beats to 0x1FFFFFF, 0x0, 0x1; last byte_enable 0x0F.
- With DDR_PRELOAD_VERIFY_EN, return a single bit flip in rd_data for beat 1 -> verify_fail=1, setup_done=1, and all 4 reads issued.
